// File: rtl/bcd_decoder.sv
// Binary switch value to four active-low seven-segment digits using an
// iterative shift-add-3 (double dabble) conversion, one input bit per clock.
module bcd_decoder #(
  parameter int N   = 10,
  parameter int SEG = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   switches,
  output logic [0:SEG-1] display_unidades,
  output logic [0:SEG-1] display_decenas,
  output logic [0:SEG-1] display_centenas,
  output logic [0:SEG-1] display_unidades_millar
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     bin;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [CNT_W-1:0] cnt;

  // Segment patterns are a..g from left to right; 0 lights a segment.
  function automatic logic [0:SEG-1] seg_encode(input logic [3:0] digit);
    logic [0:SEG-1] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Correct every nibble that would overflow past 9 once doubled.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = LOAD;
    case (state)
      LOAD:    state_next = SHIFT;
      SHIFT:   state_next = (cnt == CNT_LAST) ? UPDATE : SHIFT;
      UPDATE:  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin                     <= '0;
      bcd                     <= '0;
      cnt                     <= '0;
      display_unidades        <= seg_encode(4'd0);
      display_decenas         <= seg_encode(4'd0);
      display_centenas        <= seg_encode(4'd0);
      display_unidades_millar <= seg_encode(4'd0);
    end else begin
      case (state)
        LOAD: begin
          bin <= switches;
          bcd <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          // MSB of the binary word moves into the units nibble.
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + 1'b1;
        end
        UPDATE: begin
          display_unidades        <= seg_encode(bcd[3:0]);
          display_decenas         <= seg_encode(bcd[7:4]);
          display_centenas        <= seg_encode(bcd[11:8]);
          display_unidades_millar <= seg_encode(bcd[15:12]);
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_decoder.sv
// Directed bench for bcd_decoder: reset, latency, sampling window, mid-conversion
// reset and a table of values with hand-written BCD results.
module tb_bcd_decoder;

  localparam int N      = 10;
  localparam int SETTLE = 2 * N + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] switches = '0;
  logic [0:6]   disp_u;
  logic [0:6]   disp_d;
  logic [0:6]   disp_c;
  logic [0:6]   disp_m;
  logic [27:0]  shown;

  int n_checks = 0;
  int n_errors = 0;

  logic [27:0] exp_q[$];

  bcd_decoder #(.N(N), .SEG(7)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .switches                (switches),
    .display_unidades        (disp_u),
    .display_decenas         (disp_d),
    .display_centenas        (disp_c),
    .display_unidades_millar (disp_m)
  );

  // Clock
  always #5 clk = ~clk;

  assign shown = {disp_m, disp_c, disp_d, disp_u};

  function automatic logic [0:6] seg_of(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Expected display word {millar, centenas, decenas, unidades} from a BCD literal.
  function automatic logic [27:0] disp_of(input logic [15:0] bcd);
    return {seg_of(bcd[15:12]), seg_of(bcd[11:8]), seg_of(bcd[7:4]), seg_of(bcd[3:0])};
  endfunction

  // Driver: assert reset for a number of edges; returns on the negedge where it
  // drops, so the next rising edge is a LOAD.
  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold_value(input logic [N-1:0] v);
    @(negedge clk);
    switches = v;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    @(negedge clk);
    switches = 10'd8;
    rst = 1'b1;
    exp = disp_of(16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (shown !== exp) begin
        n_errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, shown, exp);
      end
    end
    rst = 1'b0;
    repeat (N + 1) @(negedge clk);
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL pre_first_update: got %h expected %h", shown, exp);
    end
    @(negedge clk);
    exp = disp_of(16'h0008);
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL first_update_latency: got %h expected %h", shown, exp);
    end
  endtask

  task automatic test_zero();
    logic [27:0] exp;
    hold_value(10'd0);
    exp = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL zero: got %h expected %h", shown, exp);
    end
  endtask

  task automatic test_max();
    logic [27:0] exp;
    hold_value(10'd1023);
    exp = {7'b1001111, 7'b0000001, 7'b0010010, 7'b0000110};
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL max_1023: got %h expected %h", shown, exp);
    end
  endtask

  task automatic test_999_then_7();
    logic [27:0] exp;
    hold_value(10'd999);
    exp = {7'b0000001, 7'b0000100, 7'b0000100, 7'b0000100};
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL value_999: got %h expected %h", shown, exp);
    end
    hold_value(10'd7);
    exp = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111};
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL value_7: got %h expected %h", shown, exp);
    end
  endtask

  // Switch change two cycles after LOAD must wait for the following conversion.
  task automatic test_sample_window();
    logic [27:0] exp;
    switches = 10'd500;
    apply_reset(2);
    repeat (2) @(negedge clk);
    switches = 10'd321;
    repeat (N - 1) @(negedge clk);
    exp = disp_of(16'h0000);
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL hold_before_update: got %h expected %h", shown, exp);
    end
    @(negedge clk);
    exp = disp_of(16'h0500);
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL window_first_500: got %h expected %h", shown, exp);
    end
    repeat (N + 1) @(negedge clk);
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL window_hold_500: got %h expected %h", shown, exp);
    end
    @(negedge clk);
    exp = disp_of(16'h0321);
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL window_next_321: got %h expected %h", shown, exp);
    end
  endtask

  // Runs straight after test_sample_window: the next two edges are LOAD then SHIFT.
  task automatic test_reset_mid_shift();
    logic [27:0] exp;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    switches = 10'd64;
    exp = disp_of(16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (shown !== exp) begin
        n_errors++;
        $display("FAIL mid_shift_reset[%0d]: got %h expected %h", i, shown, exp);
      end
    end
    rst = 1'b0;
    repeat (SETTLE) @(negedge clk);
    exp = disp_of(16'h0064);
    n_checks++;
    if (shown !== exp) begin
      n_errors++;
      $display("FAIL resume_after_reset: got %h expected %h", shown, exp);
    end
  endtask

  task automatic test_table();
    logic [N-1:0] vals [10];
    logic [15:0]  bcds [10];
    logic [27:0]  exp;
    vals = '{10'd5, 10'd10, 10'd99, 10'd100, 10'd256,
             10'd512, 10'd637, 10'd888, 10'd1000, 10'd1022};
    bcds = '{16'h0005, 16'h0010, 16'h0099, 16'h0100, 16'h0256,
             16'h0512, 16'h0637, 16'h0888, 16'h1000, 16'h1022};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(disp_of(bcds[i]));
      hold_value(vals[i]);
      exp = exp_q.pop_front();
      n_checks++;
      if (shown !== exp) begin
        n_errors++;
        $display("FAIL table[%0d] value %0d: got %h expected %h", i, vals[i], shown, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_999_then_7();
    test_sample_window();
    test_reset_mid_shift();
    test_table();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
